// File: rtl/rob_multi_commit.sv
// rob_multi_commit: reorder buffer with NUM_WB writeback ports and up to COMMIT_W in-order retirements per cycle
module rob_multi_commit #(
    parameter int DEPTH    = 16,
    parameter int IDX_W    = $clog2(DEPTH),
    parameter int NUM_WB   = 2,
    parameter int COMMIT_W = 2,
    parameter int XLEN     = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush_in,
    input  logic                     alloc_valid,
    output logic                     alloc_ready,
    input  logic [1:0]               alloc_kind,
    input  logic [4:0]               alloc_rd,
    input  logic [XLEN-1:0]          alloc_pc,
    input  logic                     alloc_pred_taken,
    input  logic                     alloc_done,
    input  logic [XLEN-1:0]          alloc_val,
    output logic [IDX_W-1:0]         alloc_id,
    input  logic [NUM_WB-1:0]        wb_valid,
    input  logic [NUM_WB*IDX_W-1:0]  wb_id,
    input  logic [NUM_WB*XLEN-1:0]   wb_val,
    input  logic [NUM_WB*XLEN-1:0]   wb_addr,
    input  logic [NUM_WB-1:0]        wb_taken,
    input  logic [2*IDX_W-1:0]       q_id,
    output logic [1:0]               q_ready,
    output logic [2*XLEN-1:0]        q_val,
    input  logic                     mem_st_ready,
    output logic                     mem_st_valid,
    output logic [XLEN-1:0]          mem_st_addr,
    output logic [XLEN-1:0]          mem_st_data,
    output logic [COMMIT_W-1:0]      rf_we,
    output logic [COMMIT_W*5-1:0]    rf_rd,
    output logic [COMMIT_W*XLEN-1:0] rf_val,
    output logic                     bp_valid,
    output logic [XLEN-1:0]          bp_pc,
    output logic                     bp_taken,
    output logic                     bp_mispredict,
    output logic                     redirect_valid,
    output logic [XLEN-1:0]          redirect_pc,
    output logic [IDX_W-1:0]         head_id,
    output logic [IDX_W:0]           count
);
    localparam logic [1:0] K_REG = 2'd0, K_ST = 2'd1, K_BR = 2'd2, K_JALR = 2'd3;
    logic [DEPTH-1:0] valid, done, pred, taken, valid_n, done_n, ret_mask;
    logic [1:0] kind [DEPTH];
    logic [4:0] rd [DEPTH];
    logic [XLEN-1:0] pc [DEPTH];
    logic [XLEN-1:0] val [DEPTH];
    logic [XLEN-1:0] addr [DEPTH];
    logic [IDX_W-1:0] wid [NUM_WB];
    logic [IDX_W-1:0] tail, idx, head_n;
    logic [IDX_W:0] n_ret;
    logic alloc_fire, go, ok;
    logic [COMMIT_W-1:0] rf_we_n;
    logic [COMMIT_W*5-1:0] rf_rd_n;
    logic [COMMIT_W*XLEN-1:0] rf_val_n;
    logic st_n, bp_n, bp_taken_n, bp_mis_n, redir_n;
    logic [XLEN-1:0] st_addr_n, st_data_n, bp_pc_n, redir_pc_n;
    assign alloc_ready = count < (IDX_W+1)'(DEPTH);
    assign alloc_fire = alloc_valid && alloc_ready;
    assign alloc_id = tail;
    assign head_n = head_id + n_ret[IDX_W-1:0];
    for (genvar g = 0; g < NUM_WB; g++) begin : g_wid
        assign wid[g] = wb_id[g*IDX_W +: IDX_W];
    end
    for (genvar j = 0; j < 2; j++) begin : g_q
        assign q_ready[j] = valid[q_id[j*IDX_W +: IDX_W]] && done[q_id[j*IDX_W +: IDX_W]];
        assign q_val[j*XLEN +: XLEN] = val[q_id[j*IDX_W +: IDX_W]];
    end
    // In-order scan from head; a store or control op ends the scan so at most one of each retires.
    always_comb begin
        n_ret = '0;
        ret_mask = '0;
        go = 1'b1;
        ok = 1'b0;
        idx = head_id;
        rf_we_n = '0;
        rf_rd_n = '0;
        rf_val_n = '0;
        st_n = 1'b0;
        st_addr_n = '0;
        st_data_n = '0;
        bp_n = 1'b0;
        bp_pc_n = '0;
        bp_taken_n = 1'b0;
        bp_mis_n = 1'b0;
        redir_n = 1'b0;
        redir_pc_n = '0;
        for (int k = 0; k < COMMIT_W; k++) begin
            idx = head_id + IDX_W'(k);
            ok = go && valid[idx] && done[idx] && (kind[idx] != K_ST || mem_st_ready);
            if (ok) begin
                n_ret = n_ret + (IDX_W+1)'(1);
                ret_mask[idx] = 1'b1;
                rf_we_n[k] = (kind[idx] == K_REG || kind[idx] == K_JALR) && rd[idx] != 5'd0;
                rf_rd_n[k*5 +: 5] = rd[idx];
                rf_val_n[k*XLEN +: XLEN] = val[idx];
                if (kind[idx] == K_ST) begin
                    st_n = 1'b1;
                    st_addr_n = addr[idx];
                    st_data_n = val[idx];
                end
                if (kind[idx] == K_BR) begin
                    bp_n = 1'b1;
                    bp_pc_n = pc[idx];
                    bp_taken_n = taken[idx];
                    bp_mis_n = taken[idx] != pred[idx];
                    redir_n = taken[idx] != pred[idx];
                    redir_pc_n = taken[idx] ? addr[idx] : pc[idx] + XLEN'(4);
                end
                if (kind[idx] == K_JALR) begin
                    redir_n = 1'b1;
                    redir_pc_n = addr[idx];
                end
            end
            go = ok && kind[idx] == K_REG;
        end
    end
    always_comb begin
        valid_n = valid & ~ret_mask;
        done_n = done;
        for (int i = 0; i < NUM_WB; i++)
            if (wb_valid[i] && valid[wid[i]]) done_n[wid[i]] = 1'b1;
        if (alloc_fire) begin
            valid_n[tail] = 1'b1;
            done_n[tail] = alloc_done;
        end
    end
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_WB; i++)
            if (wb_valid[i] && valid[wid[i]]) begin
                val[wid[i]] <= wb_val[i*XLEN +: XLEN];
                addr[wid[i]] <= wb_addr[i*XLEN +: XLEN];
                taken[wid[i]] <= wb_taken[i];
            end
        if (alloc_fire) begin
            kind[tail] <= alloc_kind;
            rd[tail] <= alloc_rd;
            pc[tail] <= alloc_pc;
            pred[tail] <= alloc_pred_taken;
            val[tail] <= alloc_val;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            head_id <= '0;
            tail <= '0;
            count <= '0;
            valid <= '0;
            done <= '0;
            rf_we <= '0;
            rf_rd <= '0;
            rf_val <= '0;
            mem_st_valid <= 1'b0;
            mem_st_addr <= '0;
            mem_st_data <= '0;
            bp_valid <= 1'b0;
            bp_pc <= '0;
            bp_taken <= 1'b0;
            bp_mispredict <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc <= '0;
        end else if (flush_in) begin
            tail <= head_id;
            count <= '0;
            valid <= '0;
            rf_we <= '0;
            mem_st_valid <= 1'b0;
            bp_valid <= 1'b0;
            redirect_valid <= 1'b0;
        end else begin
            head_id <= head_n;
            done <= done_n;
            tail <= redir_n ? head_n : tail + IDX_W'(alloc_fire);
            count <= redir_n ? '0 : count + (IDX_W+1)'(alloc_fire) - n_ret;
            valid <= redir_n ? '0 : valid_n;
            rf_we <= rf_we_n;
            rf_rd <= rf_rd_n;
            rf_val <= rf_val_n;
            mem_st_valid <= st_n;
            mem_st_addr <= st_addr_n;
            mem_st_data <= st_data_n;
            bp_valid <= bp_n;
            bp_pc <= bp_pc_n;
            bp_taken <= bp_taken_n;
            bp_mispredict <= bp_mis_n;
            redirect_valid <= redir_n;
            redirect_pc <= redir_pc_n;
        end
    end
endmodule

// File: doc/rob_multi_commit.md
Name: rob_multi_commit

Overview:
- Parametrised reorder buffer: circular queue of in-flight instructions, allocated in program order by the decoder, completed out of order by NUM_WB writeback ports.
- Retires up to COMMIT_W instructions per cycle.
- Drives register-file writes, store issue to the memory controller, branch-predictor updates and mispredict redirect.
- Successor of the single-commit ROB: configurable depth, writeback ports and commit width; count-based full/empty, so all DEPTH slots are usable.

Parameters:
DEPTH, 16, entry count; power of two, >= 4
IDX_W, $clog2(DEPTH), entry id width
NUM_WB, 2, writeback ports
COMMIT_W, 2, max retirements per cycle (1..4)
XLEN, 32, data width

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
flush_in  in  1  external flush: discard all entries
alloc_valid  in  1  decoder presents instruction
alloc_ready  out  1  count < DEPTH (combinational)
alloc_kind  in  2  0=reg-write, 1=store, 2=branch, 3=jalr
alloc_rd  in  5  destination register (0 = none)
alloc_pc  in  XLEN  instruction address
alloc_pred_taken  in  1  predictor guess (branch only)
alloc_done  in  1  result already known (lui/auipc/jal)
alloc_val  in  XLEN  result when alloc_done
alloc_id  out  IDX_W  tail id assigned on this handshake
wb_valid  in  NUM_WB  writeback strobes
wb_id  in  NUM_WB*IDX_W  target ids
wb_val  in  NUM_WB*XLEN  result / store data / link value
wb_addr  in  NUM_WB*XLEN  store address / branch or jalr target
wb_taken  in  NUM_WB  branch outcome
q_id  in  2*IDX_W  operand lookup ids
q_ready  out  2  entry valid and done (combinational)
q_val  out  2*XLEN  entry value (combinational)
mem_st_ready  in  1  memory controller can take a store
mem_st_valid  out  1  store issue pulse
mem_st_addr  out  XLEN  store address
mem_st_data  out  XLEN  store data
rf_we  out  COMMIT_W  per-slot register write
rf_rd  out  COMMIT_W*5  destination registers
rf_val  out  COMMIT_W*XLEN  write data
bp_valid  out  1  branch retired
bp_pc  out  XLEN  branch address
bp_taken  out  1  actual outcome
bp_mispredict  out  1  outcome != prediction
redirect_valid  out  1  flush pulse to all units
redirect_pc  out  XLEN  correct fetch address
head_id  out  IDX_W  oldest entry
count  out  IDX_W+1  occupancy

Behaviour:
Reset and flush:
- rst: head=tail=count=0; all entry valid/done cleared; every registered output 0.
- flush_in (priority below rst): tail<=head, count<=0, all valid cleared; rf_we, mem_st_valid, bp_valid, redirect_valid <= 0; alloc and writeback in that cycle are ignored.

Allocation:
- Handshake alloc_valid && alloc_ready writes entry[tail] (valid=1, done=alloc_done, val=alloc_val); tail <= tail+1 mod DEPTH.
- alloc_ready uses start-of-cycle count; no bypass from same-cycle commit (a full ROB that commits this cycle still refuses allocation).

Writeback:
- wb_valid[i] sets done, val, addr and taken of entry wb_id[i].
- Writeback to an invalid entry is ignored.
- Two ports hitting the same id: the higher port index wins.
- A writeback is visible to commit and to q_* only from the next cycle.

Commit scan:
- Registered outputs, one-cycle latency.
- Slot k (0..COMMIT_W-1) is entry head+k; it retires only if slots 0..k-1 retire and the entry is valid and done.
- Kind 0: rf_we[k] pulses only when rd != 0.
- Store (kind 1): retires only when mem_st_ready is 1 and no other store has retired this cycle; it drives mem_st_* and terminates the scan.
- Branch or jalr: terminates the scan (at most one control op per cycle).
  - Branch: bp_* pulse. bp_mispredict = taken != pred_taken. Correct pc = taken ? addr : pc+4.
  - Jalr: rf write of the link value; always redirects to addr.
- Misprediction or jalr: redirect_valid pulses and redirect_pc is set at the same edge; head advances past the retired entries; tail <= new head; count <= 0; all valid cleared; an allocation in that cycle is dropped.
- Normal cycles: count <= count + alloc - retired. head and tail wrap modulo DEPTH.

Test Plan:
- Allocate 16 kind-0 entries with alloc_done=1, rd=1..16 -> alloc_ready=0 at count=16; two entries retire per cycle; rf_we=2'b11 with rd pairs (1,2),(3,4)…; count reaches 0 after 8 cycles; ids wrap 15->0 cleanly.
- Allocate ids 0..3 not done; wb ids 3,2,1 in order, then 0 -> no commit until id 0 completes, then 0,1 retire in one cycle and 2,3 in the next.
- Store at head with mem_st_ready=0 for 3 cycles -> no retirement, mem_st_valid=0; set ready -> single mem_st_valid pulse with addr 0x30000, data 0x41; the younger ready entry retires the next cycle, not alongside the store.
- Branch pc=0x100 pred_taken=0, wb taken=1 addr=0x180, followed by 3 done entries -> redirect_valid=1, redirect_pc=0x180, bp_mispredict=1; younger entries are not committed; count=0.
- Jalr pc=0x200 rd=1 with link value 0x204 written back with addr 0x40 -> rf_we[0]=1 with rd=1 value 0x204, redirect_pc=0x40.
- With 5 entries present, assert flush_in together with alloc and a wb -> count=0, no commit pulses; rst mid-operation -> all outputs 0 the next cycle.
